operand_select_control: RTL and testbench
=========================================

// Module: operand_select_control
// PURPOSE
// - ID->EX control stage: registers, per issued instruction, the operand-2 select code
//   (00 reg, 01 imm, 10 const 1, 11 zero) consumed by the EX-stage ALU input muxes.
// - Also registers forwarding selects for operands A/B and detects load-use hazards.
// - On a load-use hazard it stalls ID and inserts one bubble into EX.
// PARAMETERS
// - REG_ADDR_W  5  register-index width
// - CNT_W       32 stall-counter width (only with OPSEL_PERF_CNT_EN)
// PORTS
// - clk             in   1       rising-edge clock
// - rstN            in   1       synchronous active-low reset
// - idValid         in   1       ID holds a valid instruction
// - idRs1,idRs2     in   5       ID source registers
// - idRd            in   5       ID destination register
// - idRegWrite      in   1       ID instruction writes rd
// - idMemRead       in   1       ID instruction is a load
// - idOp2Class      in   2       requested operand-2 source (code as above)
// - memRd,wbRd      in   5       rd of instructions currently in MEM / WB
// - memRegWrite     in   1       MEM instruction writes rd
// - wbRegWrite      in   1       WB instruction writes rd
// - exStall         in   1       downstream hold; EX outputs frozen
// - flushEx         in   1       kill the instruction entering EX (branch redirect)
// - stallId         out  1       combinational; ID/IF must hold this cycle
// - exValid         out  1       EX slot holds a real instruction
// - exInput2Select  out  2       operand-2 select for EX mux
// - exForwardA/B    out  2       00 regfile, 01 MEM/WB, 10 EX/MEM, 11 reserved (never driven)
// - exRd            out  5       rd carried into EX
// - exRegWrite,exMemRead out 1   carried control
// BEHAVIOUR
// - Reset (rstN=0 at edge): exValid=0, all EX outputs 0, state=RUN, counter=0; stallId=0.
// - States: RUN, BUBBLE. Latency: ID fields appear on ex* outputs 1 cycle after issue.
// - Hazard: hz = idValid & exValid & exMemRead & exRd!=0 &
//   (exRd==idRs1 | (idOp2Class==00 & exRd==idRs2)).
// - RUN & hz: stallId=1; next edge exValid=0 (bubble), state->BUBBLE.
// - BUBBLE: stallId=0; issue ID normally (load now in MEM, forwards via MEM/WB); ->RUN.
// - Forwarding resolved at issue vs. occupants seen next cycle in EX:
//   current EX instr (exValid&exRegWrite&exRd!=0&match) -> 10;
//   else memRegWrite&memRd!=0&match -> 01; else 00. EX/MEM has priority. x0 never forwarded.
// - Forward B computed only when idOp2Class==00; otherwise exForwardB=00.
// - Priority per edge: reset > flushEx > exStall > hazard > normal issue.
// - flushEx: exValid=0, other EX outputs cleared, state->RUN, stallId=0 that cycle.
// - exStall: all ex* outputs and state hold; stallId=1 (ID must not advance).
// - idValid=0 in RUN without stall: bubble issued (exValid=0), no hazard raised.
// - wbRd/wbRegWrite: no forwarding role; regfile write-before-read covers WB.
// CONFIGURATION
// - OPSEL_PERF_CNT_EN defined: extra output stallCount [CNT_W] counts cycles with
//   hazard-induced stallId=1; reset to 0, wraps modulo 2^CNT_W, holds during exStall.
// - Undefined: port and counter absent; all other behaviour identical.
// CONFIGURATION ENDS
// STRUCTURE
// - Package opsel_pkg: op2 select enum (OP2_REG/IMM/ONE/ZERO), forward enum
//   (FWD_RF/FWD_WB/FWD_MEM), state enum (ST_RUN/ST_BUBBLE), REG_ADDR_W const.
// - Sub-module opsel_hazard_detect: combinational hz and forward-code computation;
//   top holds state register, EX pipeline register, optional counter.
// TESTING
// - Reset: rstN=0 2 cycles with idValid=1 -> exValid=0, selects 00, stallId=0.
// - ADD x3 then ADD x4,x3,x5 (op2 00) -> second issue exForwardA=10, exForwardB=00.
// - LW x6 then ADD x7,x1,x6 -> stallId=1 one cycle, exValid=0 bubble, then exForwardB=01.
// - LW x6 then ADDI x7,x1,imm (op2 01, idRs2=6) -> no stall, exInput2Select=01, fwdB=00.
// - Load-use hazard with flushEx=1 same cycle -> exValid=0, state RUN, no bubble stall.
// - Writes to x0 then reader of x0 -> forwards 00; with OPSEL_PERF_CNT_EN, 3 load-use
//   stalls -> stallCount=3; exStall held 4 cycles -> outputs and count unchanged.

Source files
------------

// File: rtl/opsel_pkg.sv
// Shared encodings for the ID->EX operand-select control slice:
// operand-2 source codes, forwarding select codes and the issue FSM states.
package opsel_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      OP2_REG  = 2'b00,
      OP2_IMM  = 2'b01,
      OP2_ONE  = 2'b10,
      OP2_ZERO = 2'b11
   } op2_sel_e;

   // 2'b11 is reserved and never produced
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } state_e;

endpackage

// File: rtl/opsel_hazard_detect.sv
// Combinational load-use hazard detection and forwarding-select computation
// for the instruction currently sitting in ID.
module opsel_hazard_detect #(
   parameter int REG_ADDR_W = opsel_pkg::REG_ADDR_W
) (
   input  logic                  idValid,
   input  logic [REG_ADDR_W-1:0] idRs1,
   input  logic [REG_ADDR_W-1:0] idRs2,
   input  logic [1:0]            idOp2Class,
   input  logic                  exValid,
   input  logic [REG_ADDR_W-1:0] exRd,
   input  logic                  exRegWrite,
   input  logic                  exMemRead,
   input  logic [REG_ADDR_W-1:0] memRd,
   input  logic                  memRegWrite,
   output logic                  hazard,
   output opsel_pkg::fwd_e       fwdA,
   output opsel_pkg::fwd_e       fwdB
);
   import opsel_pkg::*;

   logic exWrites;
   logic memWrites;
   logic usesRs2;

   assign exWrites  = exValid & exRegWrite & (exRd != '0);
   assign memWrites = memRegWrite & (memRd != '0);
   assign usesRs2   = (idOp2Class == OP2_REG);

   // The EX occupant moves to EX/MEM next cycle, so it wins over the MEM occupant
   function automatic fwd_e pickFwd(input logic [REG_ADDR_W-1:0] rs,
                                    input logic exW, input logic [REG_ADDR_W-1:0] exR,
                                    input logic memW, input logic [REG_ADDR_W-1:0] memR);
      fwd_e sel;
      sel = FWD_RF;
      if (exW && (exR == rs)) begin
         sel = FWD_MEM;
      end else if (memW && (memR == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   assign hazard = idValid & exValid & exMemRead & (exRd != '0) &
                   ((exRd == idRs1) | (usesRs2 & (exRd == idRs2)));

   always_comb begin
      fwdA = pickFwd(idRs1, exWrites, exRd, memWrites, memRd);
      fwdB = FWD_RF;
      if (usesRs2) begin
         fwdB = pickFwd(idRs2, exWrites, exRd, memWrites, memRd);
      end
   end

endmodule

// File: rtl/operand_select_control.sv
// ID->EX control register: operand-2 select, forwarding selects and load-use bubble insertion.
// Defining OPSEL_PERF_CNT_EN adds the stallCount output counting hazard stall cycles.
module operand_select_control #(
   parameter int REG_ADDR_W = opsel_pkg::REG_ADDR_W,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  idValid,
   input  logic [REG_ADDR_W-1:0] idRs1,
   input  logic [REG_ADDR_W-1:0] idRs2,
   input  logic [REG_ADDR_W-1:0] idRd,
   input  logic                  idRegWrite,
   input  logic                  idMemRead,
   input  logic [1:0]            idOp2Class,
   input  logic [REG_ADDR_W-1:0] memRd,
   input  logic [REG_ADDR_W-1:0] wbRd,
   input  logic                  memRegWrite,
   input  logic                  wbRegWrite,
   input  logic                  exStall,
   input  logic                  flushEx,
   output logic                  stallId,
   output logic                  exValid,
   output logic [1:0]            exInput2Select,
   output logic [1:0]            exForwardA,
   output logic [1:0]            exForwardB,
   output logic [REG_ADDR_W-1:0] exRd,
   output logic                  exRegWrite,
   output logic                  exMemRead
`ifdef OPSEL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stallCount
`endif
);
   import opsel_pkg::*;

   state_e                stateQ, stateD;
   logic                  exValidQ, exValidD;
   logic [1:0]            exOp2Q, exOp2D;
   fwd_e                  exFwdAQ, exFwdAD;
   fwd_e                  exFwdBQ, exFwdBD;
   logic [REG_ADDR_W-1:0] exRdQ, exRdD;
   logic                  exRegWriteQ, exRegWriteD;
   logic                  exMemReadQ, exMemReadD;

   logic hazard;
   logic hazardStall;
   fwd_e fwdA;
   fwd_e fwdB;

   // WB results reach ID through regfile write-before-read, so WB never forwards
   logic unusedWb;
   assign unusedWb = ^{wbRd, wbRegWrite};

   opsel_hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) uHazard (
      .idValid    (idValid),
      .idRs1      (idRs1),
      .idRs2      (idRs2),
      .idOp2Class (idOp2Class),
      .exValid    (exValidQ),
      .exRd       (exRdQ),
      .exRegWrite (exRegWriteQ),
      .exMemRead  (exMemReadQ),
      .memRd      (memRd),
      .memRegWrite(memRegWrite),
      .hazard     (hazard),
      .fwdA       (fwdA),
      .fwdB       (fwdB)
   );

   assign hazardStall = ~flushEx & ~exStall & (stateQ == ST_RUN) & hazard;
   assign stallId     = ~flushEx & (exStall | ((stateQ == ST_RUN) & hazard));

   always_comb begin
      stateD      = stateQ;
      exValidD    = exValidQ;
      exOp2D      = exOp2Q;
      exFwdAD     = exFwdAQ;
      exFwdBD     = exFwdBQ;
      exRdD       = exRdQ;
      exRegWriteD = exRegWriteQ;
      exMemReadD  = exMemReadQ;
      if (flushEx || hazardStall || (!exStall && !idValid)) begin
         stateD      = hazardStall ? ST_BUBBLE : ST_RUN;
         exValidD    = 1'b0;
         exOp2D      = OP2_REG;
         exFwdAD     = FWD_RF;
         exFwdBD     = FWD_RF;
         exRdD       = '0;
         exRegWriteD = 1'b0;
         exMemReadD  = 1'b0;
      end else if (!exStall) begin
         // Normal issue; after a bubble the load has moved to MEM and forwards from there
         stateD      = ST_RUN;
         exValidD    = 1'b1;
         exOp2D      = idOp2Class;
         exFwdAD     = fwdA;
         exFwdBD     = fwdB;
         exRdD       = idRd;
         exRegWriteD = idRegWrite;
         exMemReadD  = idMemRead;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         stateQ      <= ST_RUN;
         exValidQ    <= 1'b0;
         exOp2Q      <= OP2_REG;
         exFwdAQ     <= FWD_RF;
         exFwdBQ     <= FWD_RF;
         exRdQ       <= '0;
         exRegWriteQ <= 1'b0;
         exMemReadQ  <= 1'b0;
      end else begin
         stateQ      <= stateD;
         exValidQ    <= exValidD;
         exOp2Q      <= exOp2D;
         exFwdAQ     <= exFwdAD;
         exFwdBQ     <= exFwdBD;
         exRdQ       <= exRdD;
         exRegWriteQ <= exRegWriteD;
         exMemReadQ  <= exMemReadD;
      end
   end

   assign exValid        = exValidQ;
   assign exInput2Select = exOp2Q;
   assign exForwardA     = exFwdAQ;
   assign exForwardB     = exFwdBQ;
   assign exRd           = exRdQ;
   assign exRegWrite     = exRegWriteQ;
   assign exMemRead      = exMemReadQ;

`ifdef OPSEL_PERF_CNT_EN
   logic [CNT_W-1:0] stallCntQ, stallCntD;

   always_comb begin
      stallCntD = stallCntQ;
      if (hazardStall) begin
         stallCntD = stallCntQ + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         stallCntQ <= '0;
      end else begin
         stallCntQ <= stallCntD;
      end
   end

   assign stallCount = stallCntQ;
`else
   logic [CNT_W-1:0] unusedCnt;
   assign unusedCnt = '0;
`endif

endmodule

// File: tb/tb_operand_select_control.sv
// Directed table-driven bench for operand_select_control (define OPSEL_PERF_CNT_EN to also check stallCount).
module tb_operand_select_control;

   localparam int CNT_W = 32;

   logic       clk;
   logic       rstN;
   logic       idValid;
   logic [4:0] idRs1, idRs2, idRd;
   logic       idRegWrite, idMemRead;
   logic [1:0] idOp2Class;
   logic [4:0] memRd, wbRd;
   logic       memRegWrite, wbRegWrite;
   logic       exStall, flushEx;
   logic       stallId, exValid;
   logic [1:0] exInput2Select, exForwardA, exForwardB;
   logic [4:0] exRd;
   logic       exRegWrite, exMemRead;
`ifdef OPSEL_PERF_CNT_EN
   logic [CNT_W-1:0] stallCount;
   int               expCnt;
`endif

   int numCompared;
   int numMismatched;

   typedef struct {
      string      name;
      logic       idV;
      logic [4:0] rs1, rs2, rd;
      logic       rw, mr;
      logic [1:0] op2;
      logic [4:0] memRd;
      logic       memRw, stall, flush;
      logic       eStall, eValid;
      logic [1:0] eOp2, eFA, eFB;
      logic [4:0] eRd;
      logic       eRw, eMr;
      logic       onlyValid;
   } vec_t;

   vec_t vecs[$];

   operand_select_control #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rstN          (rstN),
      .idValid       (idValid),
      .idRs1         (idRs1),
      .idRs2         (idRs2),
      .idRd          (idRd),
      .idRegWrite    (idRegWrite),
      .idMemRead     (idMemRead),
      .idOp2Class    (idOp2Class),
      .memRd         (memRd),
      .wbRd          (wbRd),
      .memRegWrite   (memRegWrite),
      .wbRegWrite    (wbRegWrite),
      .exStall       (exStall),
      .flushEx       (flushEx),
      .stallId       (stallId),
      .exValid       (exValid),
      .exInput2Select(exInput2Select),
      .exForwardA    (exForwardA),
      .exForwardB    (exForwardB),
      .exRd          (exRd),
      .exRegWrite    (exRegWrite),
      .exMemRead     (exMemRead)
`ifdef OPSEL_PERF_CNT_EN
      ,
      .stallCount    (stallCount)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard bound on run time so the bench can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(string name, logic idV, int rs1, int rs2, int rd, logic rw, logic mr,
                                  logic [1:0] op2, int mRd, logic mRw, logic stall, logic flush,
                                  logic eStall, logic eValid, logic [1:0] eOp2, logic [1:0] eFA,
                                  logic [1:0] eFB, int eRd, logic eRw, logic eMr, logic onlyValid);
      vec_t v;
      v.name = name; v.idV = idV; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
      v.rw = rw; v.mr = mr; v.op2 = op2; v.memRd = 5'(mRd); v.memRw = mRw;
      v.stall = stall; v.flush = flush; v.eStall = eStall; v.eValid = eValid;
      v.eOp2 = eOp2; v.eFA = eFA; v.eFB = eFB; v.eRd = 5'(eRd); v.eRw = eRw; v.eMr = eMr;
      v.onlyValid = onlyValid;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      numCompared++;
      if (act != exp) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one ID cycle at the falling edge, check stallId before the rising edge, EX outputs after it
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      idValid     = v.idV;
      idRs1       = v.rs1;
      idRs2       = v.rs2;
      idRd        = v.rd;
      idRegWrite  = v.rw;
      idMemRead   = v.mr;
      idOp2Class  = v.op2;
      memRd       = v.memRd;
      memRegWrite = v.memRw;
      wbRd        = v.rs1;
      wbRegWrite  = 1'b1;
      exStall     = v.stall;
      flushEx     = v.flush;
      #1;
      checkOutput({v.name, ".stallId"}, int'(stallId), int'(v.eStall));
`ifdef OPSEL_PERF_CNT_EN
      if (v.eStall && !v.stall) expCnt++;
`endif
      @(posedge clk);
      #1;
      checkOutput({v.name, ".exValid"}, int'(exValid), int'(v.eValid));
      if (!v.onlyValid) begin
         checkOutput({v.name, ".exInput2Select"}, int'(exInput2Select), int'(v.eOp2));
         checkOutput({v.name, ".exForwardA"}, int'(exForwardA), int'(v.eFA));
         checkOutput({v.name, ".exForwardB"}, int'(exForwardB), int'(v.eFB));
         checkOutput({v.name, ".exRd"}, int'(exRd), int'(v.eRd));
         checkOutput({v.name, ".exRegWrite"}, int'(exRegWrite), int'(v.eRw));
         checkOutput({v.name, ".exMemRead"}, int'(exMemRead), int'(v.eMr));
      end
`ifdef OPSEL_PERF_CNT_EN
      checkOutput({v.name, ".stallCount"}, int'(stallCount), expCnt);
`endif
   endtask

   // Two reset edges with a valid instruction presented in ID
   task automatic doReset();
      @(negedge clk);
      rstN = 1'b0; idValid = 1'b1; idRs1 = 5'd3; idRs2 = 5'd3; idRd = 5'd3;
      idRegWrite = 1'b1; idMemRead = 1'b1; idOp2Class = 2'b01;
      exStall = 1'b0; flushEx = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.exValid", int'(exValid), 0);
      checkOutput("reset.exInput2Select", int'(exInput2Select), 0);
      checkOutput("reset.exForwardA", int'(exForwardA), 0);
      checkOutput("reset.exForwardB", int'(exForwardB), 0);
      checkOutput("reset.stallId", int'(stallId), 0);
`ifdef OPSEL_PERF_CNT_EN
      expCnt = 0;
      checkOutput("reset.stallCount", int'(stallCount), 0);
`endif
      @(negedge clk);
      rstN = 1'b1; idValid = 1'b0;
   endtask

   initial begin
      numCompared = 0; numMismatched = 0;
      rstN = 1'b0; idValid = 1'b0; idRs1 = '0; idRs2 = '0; idRd = '0;
      idRegWrite = 1'b0; idMemRead = 1'b0; idOp2Class = 2'b00;
      memRd = '0; wbRd = '0; memRegWrite = 1'b0; wbRegWrite = 1'b0;
      exStall = 1'b0; flushEx = 1'b0;
`ifdef OPSEL_PERF_CNT_EN
      expCnt = 0;
`endif

      //                 name            idV rs1 rs2 rd rw mr op2  mRd mRw st fl  eSt eV eOp2 eFA   eFB   eRd eRw eMr onlyV
      vecs.push_back(mkVec("add_x3",      1,  1,  2,  3, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 2'b00, 3, 1, 0, 0));
      vecs.push_back(mkVec("fwd_ex_a",    1,  3,  5,  4, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 2'b00, 2'b10, 2'b00, 4, 1, 0, 0));
      vecs.push_back(mkVec("fwd_mem_b",   1,  9,  3,  8, 1, 0, 2'b00, 3, 1, 0, 0,  0, 1, 2'b00, 2'b00, 2'b01, 8, 1, 0, 0));
      vecs.push_back(mkVec("ex_priority", 1,  8,  8, 10, 1, 0, 2'b00, 8, 1, 0, 0,  0, 1, 2'b00, 2'b10, 2'b10, 10, 1, 0, 0));
      vecs.push_back(mkVec("lw_x6",       1,  1,  0,  6, 1, 1, 2'b01, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 2'b00, 6, 1, 1, 0));
      vecs.push_back(mkVec("lu_stall",    1,  1,  6,  7, 1, 0, 2'b00, 0, 0, 0, 0,  1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
      vecs.push_back(mkVec("lu_resume",   1,  1,  6,  7, 1, 0, 2'b00, 6, 1, 0, 0,  0, 1, 2'b00, 2'b00, 2'b01, 7, 1, 0, 0));
      vecs.push_back(mkVec("lw_x6_b",     1,  2,  0,  6, 1, 1, 2'b01, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 2'b00, 6, 1, 1, 0));
      vecs.push_back(mkVec("addi_nostall",1,  1,  6,  7, 1, 0, 2'b01, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 2'b00, 7, 1, 0, 0));
      vecs.push_back(mkVec("idle",        0,  7,  7,  9, 1, 1, 2'b00, 0, 0, 0, 0,  0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
      vecs.push_back(mkVec("x0_writer",   1,  1,  2,  0, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0));
      vecs.push_back(mkVec("x0_reader",   1,  0,  0, 11, 1, 0, 2'b00, 0, 1, 0, 0,  0, 1, 2'b00, 2'b00, 2'b00, 11, 1, 0, 0));
      vecs.push_back(mkVec("lw_x0",       1,  1,  0,  0, 1, 1, 2'b01, 0, 0, 0, 0,  0, 1, 2'b01, 2'b00, 2'b00, 0, 1, 1, 0));
      vecs.push_back(mkVec("x0_no_hz",    1,  0,  1, 12, 1, 0, 2'b00, 0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 2'b00, 12, 1, 0, 0));
      vecs.push_back(mkVec("op2_one",     1, 12, 12, 13, 1, 0, 2'b10, 0, 0, 0, 0,  0, 1, 2'b10, 2'b10, 2'b00, 13, 1, 0, 0));
      vecs.push_back(mkVec("op2_zero",    1,  0,  0, 14, 0, 0, 2'b11, 0, 0, 0, 0,  0, 1, 2'b11, 2'b00, 2'b00, 14, 0, 0, 0));

      doReset();
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
      end

      // Flush wins over a same-cycle load-use hazard: no stall, no bubble state left behind
      applyStimulus(mkVec("fl_lw",    1, 1, 0, 6, 1, 1, 2'b01, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 6, 1, 1, 0));
      applyStimulus(mkVec("fl_hz",    1, 1, 6, 7, 1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
      applyStimulus(mkVec("fl_after", 1, 1, 6, 7, 1, 0, 2'b00, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 7, 1, 0, 0));

      // Three load-use pairs, each costing exactly one stall cycle
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(mkVec("cnt_lw",     1, 1, 0, 6, 1, 1, 2'b01, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 6, 1, 1, 0));
         applyStimulus(mkVec("cnt_stall",  1, 1, 6, 7, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
         applyStimulus(mkVec("cnt_resume", 1, 1, 6, 7, 1, 0, 2'b00, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 7, 1, 0, 0));
      end
`ifdef OPSEL_PERF_CNT_EN
      checkOutput("cnt_after_3", int'(stallCount), 3);
`endif

      // Downstream hold for 4 cycles over a pending load-use hazard, then release
      applyStimulus(mkVec("hold_lw", 1, 1, 0, 6, 1, 1, 2'b01, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 6, 1, 1, 0));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mkVec("hold", 1, 1, 6, 7, 1, 0, 2'b00, 0, 0, 1, 0, 1, 1, 2'b01, 2'b00, 2'b00, 6, 1, 1, 0));
      end
`ifdef OPSEL_PERF_CNT_EN
      checkOutput("cnt_after_hold", int'(stallCount), 3);
`endif
      applyStimulus(mkVec("hold_release", 1, 1, 6, 7, 1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1));
      applyStimulus(mkVec("hold_resume",  1, 1, 6, 7, 1, 0, 2'b00, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 7, 1, 0, 0));
`ifdef OPSEL_PERF_CNT_EN
      checkOutput("cnt_final", int'(stallCount), 4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
